branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Fetch-side branch predictor that feeds the instruction ROM/PC stage. Every cycle it looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and drives `prepc` and `hit_predict` combinationally so the PC register can select them at the next posedge. The execute stage trains it through a single update port with the resolved outcome of each branch or jump.

## Interface
- `IDX_W`, default 6: index width; the BTB has 2^IDX_W entries (64).
- `TAG_W`, default 24: tag width; equals 30 − IDX_W.
- `CLK  in  1`: clock, all state updates on posedge.
- `NRST  in  1`: reset, synchronous, active-low.
- `pc  in  32`: current fetch PC (the PC-stage register output).
- `prepc  out  32`: predicted next PC.
- `hit_predict  out  1`: 1 means predicted taken, so the PC stage selects `prepc`.
- `upd_valid  in  1`: 1 means the E stage resolved a control-transfer instruction this cycle.
- `upd_pc  in  32`: PC of the resolved instruction.
- `upd_taken  in  1`: resolved direction.
- `upd_target  in  32`: resolved target address.

## Operation
- Address split: `pc[1:0]` is ignored, index = `pc[IDX_W+1:2]`, tag = `pc[31:IDX_W+2]`. The same split applies to `upd_pc`.
- Entry fields: `valid` (1), `tag` (TAG_W), `target` (32), `ctr` (2).
- Counter states: SNT=00, WNT=01, WT=10, ST=11. Counters saturate at 00 and 11 with no wrap.
- Lookup (combinational):
  - hit = valid && tag match.
  - `hit_predict` = hit && `ctr[1]`.
  - `prepc` = entry target when `hit_predict` is 1, otherwise `pc + 4` (32-bit modular add, wraps 0xFFFFFFFC→0).
- Update (posedge, only when `upd_valid`=1 and NRST=1):
  - Hit, taken: ctr = min(ctr+1, 3) and target ← `upd_target`.
  - Hit, not taken: ctr = max(ctr−1, 0). Target unchanged. The entry stays valid even at SNT.
  - Miss, taken: allocate by overwriting the indexed entry unconditionally. Set valid=1, tag, target, ctr=WT.
  - Miss, not taken: no change.
- The block has no stall input. The E stage must hold `upd_valid`=0 while stalled and on flushed bubbles, so each resolved instruction trains the BTB exactly once.

## Timing
- Lookup latency is 0 cycles (combinational from `pc`). The update becomes visible to lookup on the cycle after the update edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (read-before-write).
- Reset:
  - NRST=0 at a posedge clears all valid bits. Counters, tags and targets need not be reset.
  - An update presented in a reset cycle is discarded.
  - From the first cycle after reset, `hit_predict`=0 and `prepc`=`pc+4` for every `pc` until training occurs.
- Reset asserted mid-operation behaves identically to the first reset; there is no partial state.
- Aliasing: two PCs with the same index and different tags evict each other. A lookup with the wrong tag is a miss, never a false hit.

## Structure
- Package `bp_pkg` holds:
  - the IDX_W/TAG_W defaults;
  - the counter encodings SNT/WNT/WT/ST;
  - the BTB entry field widths;
  - the startpc constant 32768, shared with the PC stage.
- Storage is implemented as register arrays (valid as a flat 2^IDX_W vector for single-cycle clear; tag/target/ctr as arrays). It must not be inferred as block RAM, because the lookup is asynchronous.
- One sub-module, `bp_sat_counter`: pure 2-bit saturating next-state logic (inputs `ctr`, `taken`; output `ctr_next`), instantiated once on the update path.

## Test plan
- After reset, sweep `pc` = 0x8000..0x80FC in steps of 4 → `hit_predict`=0 and `prepc`=`pc+4` at every point.
- Update `upd_pc`=0x8010, taken, target 0x8100. On the next cycle, `pc`=0x8010 → `hit_predict`=1, `prepc`=0x8100. In the same cycle as the update, `pc`=0x8010 → `hit_predict`=0.
- Counter walk on 0x8010 starting from WT:
  - not-taken ×1 → `hit_predict`=0 (WNT);
  - taken ×3 → reaches ST, `hit_predict`=1;
  - not-taken ×1 → `hit_predict` stays 1 (WT);
  - not-taken ×3 → saturates at SNT, `hit_predict`=0 with the entry still valid.
- Aliasing: train 0x8010 taken → 0x8100, then 0x8110 taken → 0x9000 (same index, IDX_W=6). Result: `pc`=0x8010 misses (`prepc`=0x8014), `pc`=0x8110 → `prepc`=0x9000.
- Hit, taken, new target: with 0x8010 at ST, update taken with target 0x8200 → `prepc`=0x8200 next cycle. A not-taken miss on 0x8400 leaves the BTB unchanged.
- With an entry trained, assert NRST=0 for one cycle together with `upd_valid`=1 → all lookups miss afterwards and the concurrent update is not stored. Lookup at `pc`=0xFFFFFFFC on a miss → `prepc`=0x00000000.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and types for the fetch-side branch predictor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   BP_IDX_W / BP_TAG_W : default BTB index / tag widths (tag = 30 - index)
//   ctr_e               : 2-bit saturating direction counter encodings
//   BP_*_W              : BTB entry field widths
//   BP_STARTPC          : reset fetch address, shared with the PC stage
package bp_pkg;

    localparam int BP_IDX_W = 6;
    localparam int BP_TAG_W = 30 - BP_IDX_W;

    // BTB entry field widths (tag width follows the index width).
    localparam int BP_VALID_W  = 1;
    localparam int BP_TARGET_W = 32;
    localparam int BP_CTR_W    = 2;

    // Direction counter; the MSB alone is the taken prediction.
    typedef enum logic [BP_CTR_W-1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [31:0] BP_STARTPC = 32'd32768;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic for BTB direction training.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; evaluated every cycle, caller decides whether to store it.
//
// Ports:
//   ctr      in  : current counter state
//   taken    in  : resolved branch direction
//   ctr_next out : counter moved one step toward the outcome, held at SNT/ST
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e ctr_next
);

    always_comb begin
        ctr_next = ctr;
        case (ctr)
            SNT: ctr_next = taken ? WNT : SNT;
            WNT: ctr_next = taken ? WT  : SNT;
            WT:  ctr_next = taken ? ST  : WNT;
            ST:  ctr_next = taken ? ST  : WT;
            default: ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts next fetch PC from the current PC.
// Latency: lookup is 0 cycles (combinational); training is visible the cycle after the update edge.
// Backpressure: none; the execute stage must present each resolved branch exactly once.
//
// Ports:
//   CLK, NRST         : clock, synchronous active-low reset (clears all valid bits)
//   pc                : current fetch PC
//   prepc             : predicted next PC (BTB target when predicted taken, else pc+4)
//   hit_predict       : 1 when the BTB hits and the counter says taken
//   upd_valid         : a resolved control transfer is presented this cycle
//   upd_pc            : PC of the resolved instruction
//   upd_taken         : resolved direction
//   upd_target        : resolved target address
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic                   CLK,
    input  logic                   NRST,
    input  logic [31:0]            pc,
    output logic [31:0]            prepc,
    output logic                   hit_predict,
    input  logic                   upd_valid,
    input  logic [31:0]            upd_pc,
    input  logic                   upd_taken,
    input  logic [BP_TARGET_W-1:0] upd_target
);

    localparam int NENT = 1 << IDX_W;

    // ------------------------------------------------------------------
    // Storage. Kept as flops: the lookup is asynchronous, and valid is a
    // flat vector so reset can clear every entry in a single cycle.
    // Tag/target/counter are deliberately not reset; valid gates them.
    // ------------------------------------------------------------------
    logic [NENT-1:0]        valid_q;
    logic [NENT-1:0]        valid_d;
    logic [TAG_W-1:0]       tag_q    [NENT];
    logic [BP_TARGET_W-1:0] target_q [NENT];
    ctr_e                   ctr_q    [NENT];

    // ------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    ctr_e             lk_ctr;

    assign lk_idx = pc[IDX_W+1:2];
    assign lk_tag = pc[31:IDX_W+2];

    always_comb begin
        lk_ctr      = ctr_q[lk_idx];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        hit_predict = lk_hit && lk_ctr[1];
        // Fall-through add wraps modulo 2^32 by construction.
        prepc       = hit_predict ? target_q[lk_idx] : (pc + 32'd4);
    end

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             up_we;
    ctr_e             up_ctr;
    ctr_e             up_ctr_next;
    ctr_e             up_ctr_wr;

    // Byte offset of the resolved PC carries no information for the BTB.
    logic             unused_upd_lsb;
    assign unused_upd_lsb = ^upd_pc[1:0];

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];

    bp_sat_counter u_sat_counter (
        .ctr      (up_ctr),
        .taken    (upd_taken),
        .ctr_next (up_ctr_next)
    );

    always_comb begin
        up_ctr = ctr_q[up_idx];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        // A not-taken miss never allocates; everything else writes the
        // indexed entry. Updates during reset are dropped.
        up_we  = NRST && upd_valid && (upd_taken || up_hit);
        // A fresh allocation starts weakly taken; an existing entry trains.
        up_ctr_wr = up_hit ? up_ctr_next : WT;
    end

    always_comb begin
        valid_d = valid_q;
        // Entries are never invalidated by training, only by reset, so a
        // counter that decays to SNT still owns its slot.
        if (upd_valid && upd_taken) begin
            valid_d[up_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (up_we) begin
            // On a hit the tag is rewritten with the same value, which keeps
            // the write enable shared between allocation and training.
            tag_q[up_idx] <= up_tag;
            ctr_q[up_idx] <= up_ctr_wr;
            if (upd_taken) begin
                target_q[up_idx] <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

    logic        CLK;
    logic        NRST;
    logic [31:0] pc;
    logic [31:0] prepc;
    logic        hit_predict;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    int n_chk  = 0;
    int n_pass = 0;

    // Scoreboard: one entry per driven lookup cycle.
    logic        exp_hit_q [$];
    logic [31:0] exp_pc_q  [$];
    string       exp_tag_q [$];

    branch_target_predictor dut (
        .CLK         (CLK),
        .NRST        (NRST),
        .pc          (pc),
        .prepc       (prepc),
        .hit_predict (hit_predict),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, mid-cycle after inputs settle.
    always @(negedge CLK) begin
        if (exp_hit_q.size() > 0) begin
            logic        eh;
            logic [31:0] ep;
            string       et;
            eh = exp_hit_q.pop_front();
            ep = exp_pc_q.pop_front();
            et = exp_tag_q.pop_front();
            chk({et, ".hit"},   {31'd0, hit_predict}, {31'd0, eh});
            chk({et, ".prepc"}, prepc, ep);
        end
    end

    // One cycle: drive lookup pc plus an optional update, push the expected lookup result.
    task automatic step(input string tag, input logic [31:0] lpc,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt,
                        input logic eh, input logic [31:0] ep);
        @(posedge CLK);
        #1;
        pc         = lpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        exp_hit_q.push_back(eh);
        exp_pc_q.push_back(ep);
        exp_tag_q.push_back(tag);
    endtask

    task automatic lookup(input string tag, input logic [31:0] lpc,
                          input logic eh, input logic [31:0] ep);
        step(tag, lpc, 1'b0, 32'd0, 1'b0, 32'd0, eh, ep);
    endtask

    // Training cycle with an untrained lookup (index 0, never allocated).
    task automatic train(input string tag, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt);
        step(tag, 32'h8000, 1'b1, upc, ut, utgt, 1'b0, 32'h8004);
    endtask

    initial begin
        NRST = 1'b0; pc = 32'd0;
        upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0; upd_target = 32'd0;
        repeat (3) @(posedge CLK);
        #1 NRST = 1'b1;

        // Post-reset sweep: everything misses.
        for (int i = 0; i < 64; i++) begin
            lookup("sweep", 32'h8000 + 32'(i * 4), 1'b0, 32'h8004 + 32'(i * 4));
        end

        // Allocation, with same-cycle lookup seeing pre-update contents.
        step("rbw_alloc", 32'h8010, 1'b1, 32'h8010, 1'b1, 32'h8100, 1'b0, 32'h8014);
        lookup("alloc", 32'h8010, 1'b1, 32'h8100);

        // Counter walk from WT.
        train("nt1", 32'h8010, 1'b0, 32'h0);
        lookup("wnt", 32'h8010, 1'b0, 32'h8014);
        for (int i = 0; i < 3; i++) train("t3", 32'h8010, 1'b1, 32'h8100);
        lookup("st", 32'h8010, 1'b1, 32'h8100);
        train("nt_st", 32'h8010, 1'b0, 32'h0);
        lookup("wt", 32'h8010, 1'b1, 32'h8100);
        for (int i = 0; i < 3; i++) train("nt3", 32'h8010, 1'b0, 32'h0);
        lookup("snt", 32'h8010, 1'b0, 32'h8014);
        // Still valid at SNT: a taken update trains to WNT instead of reallocating at WT.
        train("t_snt", 32'h8010, 1'b1, 32'h8100);
        lookup("snt_valid", 32'h8010, 1'b0, 32'h8014);

        // Aliasing on index 4.
        train("alias_a", 32'h8010, 1'b1, 32'h8100);
        lookup("alias_a_hit", 32'h8010, 1'b1, 32'h8100);
        train("alias_b", 32'h8110, 1'b1, 32'h9000);
        lookup("alias_a_miss", 32'h8010, 1'b0, 32'h8014);
        lookup("alias_b_hit", 32'h8110, 1'b1, 32'h9000);

        // Hit-taken retarget.
        train("re_alloc", 32'h8010, 1'b1, 32'h8100);
        train("to_st", 32'h8010, 1'b1, 32'h8100);
        train("retarget", 32'h8010, 1'b1, 32'h8200);
        lookup("new_tgt", 32'h8010, 1'b1, 32'h8200);
        train("nt_miss", 32'h8400, 1'b0, 32'hDEAD0000);
        lookup("unchanged", 32'h8010, 1'b1, 32'h8200);
        lookup("nt_no_alloc", 32'h8400, 1'b0, 32'h8404);
        step("rbw_hit", 32'h8010, 1'b1, 32'h8010, 1'b1, 32'h8300, 1'b1, 32'h8200);
        lookup("rbw_after", 32'h8010, 1'b1, 32'h8300);

        // Reset for one cycle with a concurrent update that must be dropped.
        @(posedge CLK);
        #1;
        NRST = 1'b0; pc = 32'h8010;
        upd_valid = 1'b1; upd_pc = 32'h8020; upd_taken = 1'b1; upd_target = 32'hA000;
        @(posedge CLK);
        #1;
        NRST = 1'b1; upd_valid = 1'b0;
        lookup("rst_8010", 32'h8010, 1'b0, 32'h8014);
        lookup("rst_8020", 32'h8020, 1'b0, 32'h8024);
        lookup("rst_8110", 32'h8110, 1'b0, 32'h8114);
        lookup("wrap", 32'hFFFFFFFC, 1'b0, 32'h00000000);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_hit_q.size() > 0; i++) @(posedge CLK);
        if (exp_hit_q.size() > 0) begin
            chk("drain_timeout", 32'(exp_hit_q.size()), 32'd0);
        end
        @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
